// File: rtl/ct_f_spsram_512x59_ctrl_pkg.sv
// Shared constants for the 512x59 single-port SRAM front-end: FSM encodings,
// array geometry and write-mask group boundaries.
package ct_f_spsram_512x59_ctrl_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 59;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // The macro's bit enables are only honoured per group: [58], [57:29], [28:0]
  localparam int GRP2_BIT = 58;
  localparam int GRP1_MSB = 57;
  localparam int GRP1_LSB = 29;
  localparam int GRP0_MSB = 28;
  localparam int GRP0_LSB = 0;

  function automatic logic mask_uniform(input logic [DATA_W-1:0] m);
    logic [GRP1_MSB-GRP1_LSB:0] g1;
    logic [GRP0_MSB-GRP0_LSB:0] g0;
    g1 = m[GRP1_MSB:GRP1_LSB];
    g0 = m[GRP0_MSB:GRP0_LSB];
    return ((&g1) || !(|g1)) && ((&g0) || !(|g0));
  endfunction

endpackage

// File: rtl/ct_f_spsram_512x59_ctrl_rdata_fifo.sv
// Two-entry read-data buffer; slot0 is always the head so rdata comes
// straight from a register. Push and pop may coincide at any count.
module ct_f_spsram_rdata_fifo
  import ct_f_spsram_512x59_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] slot0_reg, slot0_next;
  logic [DATA_WIDTH-1:0] slot1_reg, slot1_next;
  logic [1:0]            count_reg, count_next;
  logic                  pop_eff;
  logic                  push_eff;

  assign full      = (count_reg == 2'd2);
  assign empty     = (count_reg == 2'd0);
  assign count     = count_reg;
  assign head_data = slot0_reg;

  always_comb begin
    pop_eff    = pop && !empty;
    push_eff   = push && (!full || pop_eff);
    slot0_next = slot0_reg;
    slot1_next = slot1_reg;
    case (count_reg)
      2'd0: begin
        if (push_eff) slot0_next = push_data;
      end
      2'd1: begin
        if (push_eff && pop_eff) slot0_next = push_data;
        else if (push_eff)       slot1_next = push_data;
      end
      default: begin
        if (pop_eff) begin
          slot0_next = slot1_reg;
          if (push_eff) slot1_next = push_data;
        end
      end
    endcase
    count_next = count_reg + {1'b0, push_eff} - {1'b0, pop_eff};
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      slot0_reg <= '0;
      slot1_reg <= '0;
      count_reg <= 2'd0;
    end else begin
      slot0_reg <= slot0_next;
      slot1_reg <= slot1_next;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/ct_f_spsram_512x59_ctrl.sv
// Front-end for the 512x59 single-port SRAM: zero-fill after reset, then
// one write-or-read access per cycle with bounded read starvation.
module ct_f_spsram_512x59_ctrl
  import ct_f_spsram_512x59_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH    = ADDR_W,
  parameter int DATA_WIDTH    = DATA_W,
  parameter int WR_STARVE_MAX = 4,
  parameter int INIT_EN       = 1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  wr_vld,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_rdy,
  input  logic                  rd_vld,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_rdy,
  output logic                  rdata_vld,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rdata_rdy,
  output logic                  init_done,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int               SW         = $clog2(WR_STARVE_MAX + 1);
  localparam logic [SW-1:0]    STARVE_MAX = SW'(WR_STARVE_MAX);

  logic [0:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] init_cnt_reg, init_cnt_next;
  logic [SW-1:0]         starve_cnt_reg, starve_cnt_next;
  logic                  inflight_reg;

  logic       run;
  logic       init_acc;
  logic       force_rd;
  logic       rd_space;
  logic       grant_wr;
  logic       grant_rd;
  logic [1:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;

  assign run       = (state_reg == ST_RUN);
  assign init_done = run;
  // Gated by cpurst_b so the macro sees no access while reset is held
  assign init_acc  = (state_reg == ST_INIT) && (INIT_EN != 0) && cpurst_b;
  assign force_rd  = (starve_cnt_reg >= STARVE_MAX);
  // Reserve FIFO room for every read already issued to the macro
  assign rd_space  = !fifo_full && !((fifo_count == 2'd1) && inflight_reg);

  assign rd_rdy   = run && rd_space && (!wr_vld || force_rd);
  assign wr_rdy   = run && !(rd_vld && rd_space && force_rd);
  assign grant_rd = rd_vld && rd_rdy;
  assign grant_wr = wr_vld && wr_rdy;

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (init_acc) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_cnt_reg;
    end else if (grant_wr) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~wr_mask;
      sram_a    = wr_addr;
      sram_d    = wr_data;
    end else if (grant_rd) begin
      sram_cen  = 1'b0;
      sram_a    = rd_addr;
    end
  end

  always_comb begin
    state_next      = state_reg;
    init_cnt_next   = init_cnt_reg;
    starve_cnt_next = starve_cnt_reg;
    if (state_reg == ST_INIT) begin
      if (INIT_EN == 0) begin
        state_next = ST_RUN;
      end else begin
        init_cnt_next = init_cnt_reg + 1'b1;
        if (&init_cnt_reg) state_next = ST_RUN;
      end
    end
    // Saturates at the limit while a forced read waits for FIFO space
    if (!run || grant_rd || !rd_vld) starve_cnt_next = '0;
    else if (grant_wr && !force_rd)  starve_cnt_next = starve_cnt_reg + 1'b1;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_reg      <= ST_INIT;
      init_cnt_reg   <= '0;
      starve_cnt_reg <= '0;
      inflight_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      init_cnt_reg   <= init_cnt_next;
      starve_cnt_reg <= starve_cnt_next;
      inflight_reg   <= grant_rd;
    end
  end

  assign rdata_vld = !fifo_empty;

  ct_f_spsram_rdata_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rdata_fifo (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .push           (inflight_reg),
    .push_data      (sram_q),
    .pop            (rdata_vld && rdata_rdy),
    .head_data      (rdata),
    .count          (fifo_count),
    .full           (fifo_full),
    .empty          (fifo_empty)
  );

endmodule

// File: tb/tb_ct_f_spsram_512x59_ctrl.sv
// Bench for the SRAM front-end: behavioural macro, reference memory and a
// read-data scoreboard filled on read accept and drained on rdata handshake.
module tb_ct_f_spsram_512x59_ctrl;
  import ct_f_spsram_512x59_ctrl_pkg::*;

  localparam int AW = 9;
  localparam int DW = 59;

  logic          forever_cpuclk = 1'b0;
  logic          cpurst_b;
  logic          wr_vld, rd_vld, rdata_rdy;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, wr_mask;
  logic          wr_rdy, rd_rdy, rdata_vld, init_done;
  logic [DW-1:0] rdata;
  logic          sram_cen, sram_gwen;
  logic [DW-1:0] sram_wen, sram_d, sram_q;
  logic [AW-1:0] sram_a;

  int            tests_run = 0;
  int            tests_failed = 0;
  int            cyc = 0;
  int            rd_acc_cyc = 0;
  logic [DW-1:0] sram_mem [0:511];
  logic [DW-1:0] exp_mem  [0:511];
  logic [DW-1:0] sb [$];
  logic [DW-1:0] last_rdata;

  ct_f_spsram_512x59_ctrl dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .wr_vld         (wr_vld),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_mask        (wr_mask),
    .wr_rdy         (wr_rdy),
    .rd_vld         (rd_vld),
    .rd_addr        (rd_addr),
    .rd_rdy         (rd_rdy),
    .rdata_vld      (rdata_vld),
    .rdata          (rdata),
    .rdata_rdy      (rdata_rdy),
    .init_done      (init_done),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_a         (sram_a),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;
  always @(posedge forever_cpuclk) cyc <= cyc + 1;

  // Behavioural macro: bit-masked write, read data one cycle later
  always @(posedge forever_cpuclk) begin
    if (!sram_cen) begin
      if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= sram_mem[sram_a];
    end
  end

  always @(posedge forever_cpuclk) begin
    if (cpurst_b && wr_vld)
      assert (mask_uniform(wr_mask)) else $error("[TB] non-uniform wr_mask %h", wr_mask);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge forever_cpuclk) begin
    logic [DW-1:0] e;
    if (!cpurst_b) begin
      sb.delete();
    end else begin
      if (rdata_vld && rdata_rdy) begin
        last_rdata = rdata;
        if (sb.size() == 0) begin
          chk("rd_unexpected", 64'(rdata_vld), 64'(0));
        end else begin
          e = sb.pop_front();
          $display("[TB] rdata 0x%0h expected 0x%0h", rdata, e);
          chk("rd_data", 64'(rdata), 64'(e));
        end
      end
      if (rd_vld && rd_rdy) begin
        chk("sram_rd_bus", 64'({sram_cen, sram_gwen, sram_a}), 64'({2'b01, rd_addr}));
        sb.push_back(exp_mem[rd_addr]);
      end
      if (wr_vld && wr_rdy) begin
        chk("sram_wr_bus", 64'({sram_cen, sram_gwen, sram_a}), 64'({2'b00, wr_addr}));
        exp_mem[wr_addr] = (exp_mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
      end
    end
  end

  task automatic chk_reset(input string tag);
    logic [DW-1:0] ones;
    ones = '1;
    chk({tag, "_wr_rdy"},    64'(wr_rdy),    64'(0));
    chk({tag, "_rd_rdy"},    64'(rd_rdy),    64'(0));
    chk({tag, "_rdata_vld"}, 64'(rdata_vld), 64'(0));
    chk({tag, "_rdata"},     64'(rdata),     64'(0));
    chk({tag, "_init_done"}, 64'(init_done), 64'(0));
    chk({tag, "_cen"},       64'(sram_cen),  64'(1));
    chk({tag, "_gwen"},      64'(sram_gwen), 64'(1));
    chk({tag, "_wen"},       64'(sram_wen),  64'(ones));
    chk({tag, "_a"},         64'(sram_a),    64'(0));
    chk({tag, "_d"},         64'(sram_d),    64'(0));
  endtask

  // Called at posedge+1 of the first cycle after reset release
  task automatic run_init(input string tag);
    int nw = 0, err = 0, first = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge forever_cpuclk);
      if (init_done) begin
        first = k;
        break;
      end
      if (!sram_cen) begin
        if (sram_gwen !== 1'b0 || sram_wen !== '0 || sram_d !== '0 || sram_a !== AW'(nw)) err++;
        nw++;
      end
      if (wr_rdy || rd_rdy || rdata_vld) err++;
    end
    chk({tag, "_init_writes"}, 64'(nw), 64'(512));
    chk({tag, "_init_seq_err"}, 64'(err), 64'(0));
    chk({tag, "_init_done_cyc"}, 64'(first), 64'(513));
    for (int i = 0; i < 512; i++) exp_mem[i] = '0;
    @(posedge forever_cpuclk); #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    int n = 0;
    bit ok = 0;
    wr_vld = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    while (!ok && n < 20) begin
      @(negedge forever_cpuclk);
      ok = wr_rdy;
      n++;
    end
    chk("wr_accept", 64'(ok), 64'(1));
    @(posedge forever_cpuclk); #1;
    wr_vld = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    int n = 0;
    bit ok = 0;
    rd_vld = 1'b1; rd_addr = a;
    while (!ok && n < 20) begin
      @(negedge forever_cpuclk);
      ok = rd_rdy;
      n++;
    end
    rd_acc_cyc = cyc;
    chk("rd_accept", 64'(ok), 64'(1));
    @(posedge forever_cpuclk); #1;
    rd_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge forever_cpuclk);
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'(0));
    @(posedge forever_cpuclk); #1;
  endtask

  initial begin
    int nw, nr, rd_wait, maxw, idx, rel, acc, lat;
    bit wg, rg, last_rdy;
    logic [AW-1:0] t4_addr [3];

    for (int i = 0; i < 512; i++) sram_mem[i] = DW'({$urandom(), $urandom()});
    cpurst_b = 1'b0; wr_vld = 1'b0; rd_vld = 1'b0; rdata_rdy = 1'b1;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_mask = '1;
    last_rdata = '1;

    // 1: reset state, zero-fill, read of the last entry
    repeat (3) @(negedge forever_cpuclk);
    chk_reset("rst");
    @(posedge forever_cpuclk); #1;
    cpurst_b = 1'b1;
    run_init("t1");
    last_rdata = '1;
    do_read(9'h1FF);
    drain();
    chk("t1_rd_1ff", 64'(last_rdata), 64'(0));

    // 2: full-mask write then immediate read, latency 2
    do_write(9'h0A3, 59'h5A5A5A5A5A5A5A5, '1);
    do_read(9'h0A3);
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge forever_cpuclk);
      if (rdata_vld) begin
        lat = cyc - rd_acc_cyc;
        break;
      end
    end
    chk("t2_latency", 64'(lat), 64'(2));
    @(posedge forever_cpuclk); #1;
    drain();
    chk("t2_rdata", 64'(last_rdata), 64'(59'h5A5A5A5A5A5A5A5));

    // 3: both channels saturated -> 4 writes then a forced read
    nw = 0; nr = 0; rd_wait = 0; maxw = 0;
    wr_mask = '1;
    wr_addr = 9'h100 + AW'($urandom_range(0, 7));
    wr_data = DW'({$urandom(), $urandom()});
    rd_addr = 9'h100 + AW'($urandom_range(0, 7));
    wr_vld = 1'b1; rd_vld = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge forever_cpuclk);
      wg = wr_vld && wr_rdy;
      rg = rd_vld && rd_rdy;
      nw += int'(wg);
      nr += int'(rg);
      if (rg) rd_wait = 0;
      else begin
        rd_wait++;
        if (rd_wait > maxw) maxw = rd_wait;
      end
      @(posedge forever_cpuclk); #1;
      if (wg) begin
        wr_addr = 9'h100 + AW'($urandom_range(0, 7));
        wr_data = DW'({$urandom(), $urandom()});
      end
      if (rg) rd_addr = 9'h100 + AW'($urandom_range(0, 7));
    end
    wr_vld = 1'b0; rd_vld = 1'b0;
    chk("t3_wr_grants", 64'(nw), 64'(20));
    chk("t3_rd_grants", 64'(nr), 64'(5));
    chk("t3_max_rd_wait", 64'(maxw), 64'(4));
    drain();

    // 4: consumer stalled -> only two reads accepted, third after release
    t4_addr[0] = 9'h020; t4_addr[1] = 9'h021; t4_addr[2] = 9'h022;
    do_write(9'h020, 59'h111111111111111, '1);
    do_write(9'h021, 59'h222222222222222, '1);
    do_write(9'h022, 59'h333333333333333, '1);
    rdata_rdy = 1'b0;
    idx = 0; last_rdy = 1'b1;
    rd_vld = 1'b1; rd_addr = t4_addr[0];
    for (int i = 0; i < 6; i++) begin
      @(negedge forever_cpuclk);
      last_rdy = rd_rdy;
      if (rd_rdy) idx++;
      @(posedge forever_cpuclk); #1;
      if (idx < 3) rd_addr = t4_addr[idx];
    end
    chk("t4_accepts", 64'(idx), 64'(2));
    chk("t4_rd_rdy_low", 64'(last_rdy), 64'(0));
    chk("t4_rdata_vld", 64'(rdata_vld), 64'(1));
    rdata_rdy = 1'b1;
    rel = cyc; acc = rel + 100;
    for (int k = 0; k < 10; k++) begin
      @(negedge forever_cpuclk);
      if (rd_rdy) begin
        acc = cyc;
        break;
      end
    end
    chk("t4_third_delay", 64'(acc - rel), 64'(1));
    @(posedge forever_cpuclk); #1;
    rd_vld = 1'b0;
    drain();

    // 5: lower group only over a zero entry
    do_write(9'h055, '1, 59'h00000001FFFFFFF);
    last_rdata = '0;
    do_read(9'h055);
    drain();
    chk("t5_rdata", 64'(last_rdata), 64'(59'h00000001FFFFFFF));

    // 6: reset with the read path fully occupied
    rdata_rdy = 1'b0;
    idx = 0;
    rd_vld = 1'b1; rd_addr = t4_addr[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge forever_cpuclk);
      if (rd_vld && rd_rdy) idx++;
      @(posedge forever_cpuclk); #1;
      if (idx >= 2) rd_vld = 1'b0;
      else          rd_addr = t4_addr[idx];
    end
    chk("t6_accepts", 64'(idx), 64'(2));
    chk("t6_pre_vld", 64'(rdata_vld), 64'(1));
    cpurst_b = 1'b0;
    #1;
    chk("t6_rst_vld_now", 64'(rdata_vld), 64'(0));
    chk("t6_rst_rdata_now", 64'(rdata), 64'(0));
    @(negedge forever_cpuclk);
    chk_reset("t6_rst");
    @(posedge forever_cpuclk); #1;
    cpurst_b = 1'b1;
    rdata_rdy = 1'b1;
    run_init("t6");
    last_rdata = '1;
    do_read(9'h0A3);
    drain();
    chk("t6_refill_zero", 64'(last_rdata), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
